// File: rtl/isdu_pkg.sv
// rtl/isdu_pkg.sv - state encodings, control word layout and mux/ALU codes for the ISDU
package isdu_pkg;

  typedef enum logic [4:0] {
    HALTED = 5'd0,  S18   = 5'd1,  S33_1 = 5'd2,  S33_2 = 5'd3,
    S35    = 5'd4,  S32   = 5'd5,  S01   = 5'd6,  S05   = 5'd7,
    S09    = 5'd8,  S00   = 5'd9,  S22   = 5'd10, S12   = 5'd11,
    S04    = 5'd12, S21   = 5'd13, S06   = 5'd14, S25_1 = 5'd15,
    S25_2  = 5'd16, S27   = 5'd17, S07   = 5'd18, S23   = 5'd19,
    S16_1  = 5'd20, S16_2 = 5'd21, P1    = 5'd22, P2    = 5'd23
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;

  localparam logic [1:0] ALUK_ADD   = 2'd0;
  localparam logic [1:0] ALUK_AND   = 2'd1;
  localparam logic [1:0] ALUK_NOT   = 2'd2;
  localparam logic [1:0] ALUK_PASSA = 2'd3;

  localparam logic [1:0] PCMUX_PC1   = 2'd0;
  localparam logic [1:0] PCMUX_BUS   = 2'd1;
  localparam logic [1:0] PCMUX_ADDER = 2'd2;

  localparam logic [1:0] ADDR2MUX_ZERO  = 2'd0;
  localparam logic [1:0] ADDR2MUX_OFF6  = 2'd1;
  localparam logic [1:0] ADDR2MUX_OFF9  = 2'd2;
  localparam logic [1:0] ADDR2MUX_OFF11 = 2'd3;

  localparam logic ADDR1MUX_PC     = 1'b0;
  localparam logic ADDR1MUX_SR1    = 1'b1;
  localparam logic DRMUX_IR11_9    = 1'b0;
  localparam logic DRMUX_R7        = 1'b1;
  localparam logic SR1MUX_IR8_6    = 1'b0;
  localparam logic SR1MUX_IR11_9   = 1'b1;

  typedef struct packed {
    logic       LD_MAR;
    logic       LD_MDR;
    logic       LD_IR;
    logic       LD_BEN;
    logic       LD_CC;
    logic       LD_REG;
    logic       LD_PC;
    logic       LD_LED;
    logic       GatePC;
    logic       GateMDR;
    logic       GateALU;
    logic       GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX;
    logic       SR1MUX;
    logic       SR2MUX;
    logic       ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
  } ctrl_t;

endpackage

// File: rtl/isdu_ctrl.sv
// rtl/isdu_ctrl.sv - Moore FSM sequencing fetch/decode/execute for the LC-3 style datapath
module isdu_ctrl
  import isdu_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [3:0]  Opcode,
  input  logic        IR_5,
  input  logic        IR_11,
  input  logic        BEN,
  output ctrl_t       ctrl,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic [4:0]  state_o
);

  state_t state_q, state_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= HALTED;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      HALTED: if (Run) state_d = S18;
      S18:    state_d = S33_1;
      S33_1:  state_d = S33_2;
      S33_2:  state_d = S35;
      S35:    state_d = S32;
      S32: begin
        case (Opcode)
          OP_ADD:  state_d = S01;
          OP_AND:  state_d = S05;
          OP_NOT:  state_d = S09;
          OP_BR:   state_d = S00;
          OP_JMP:  state_d = S12;
          OP_JSR:  state_d = S04;
          OP_LDR:  state_d = S06;
          OP_STR:  state_d = S07;
          OP_PSE:  state_d = P1;
          default: state_d = S18;
        endcase
      end
      S00:    state_d = BEN ? S22 : S18;
      S04:    state_d = S21;
      S06:    state_d = S25_1;
      S25_1:  state_d = S25_2;
      S25_2:  state_d = S27;
      S07:    state_d = S23;
      S23:    state_d = S16_1;
      S16_1:  state_d = S16_2;
      P1:     if (Continue) state_d = P2;
      P2:     if (!Continue) state_d = S18;
      default: state_d = S18;
    endcase
  end

  // IR_5/IR_11 come from the IR register, which is stable for the whole execute phase.
  always_comb begin
    ctrl   = '0;
    Mem_OE = 1'b1;
    Mem_WE = 1'b1;
    case (state_q)
      S18: begin
        ctrl.LD_MAR = 1'b1;
        ctrl.GatePC = 1'b1;
        ctrl.LD_PC  = 1'b1;
        ctrl.PCMUX  = PCMUX_PC1;
      end
      S33_1, S25_1: Mem_OE = 1'b0;
      S33_2, S25_2: begin
        Mem_OE      = 1'b0;
        ctrl.LD_MDR = 1'b1;
      end
      S35: begin
        ctrl.GateMDR = 1'b1;
        ctrl.LD_IR   = 1'b1;
      end
      S32: ctrl.LD_BEN = 1'b1;
      S01, S05: begin
        ctrl.GateALU = 1'b1;
        ctrl.LD_REG  = 1'b1;
        ctrl.LD_CC   = 1'b1;
        ctrl.SR2MUX  = IR_5;
        ctrl.ALUK    = (state_q == S01) ? ALUK_ADD : ALUK_AND;
      end
      S09: begin
        ctrl.GateALU = 1'b1;
        ctrl.LD_REG  = 1'b1;
        ctrl.LD_CC   = 1'b1;
        ctrl.ALUK    = ALUK_NOT;
      end
      S22: begin
        ctrl.LD_PC    = 1'b1;
        ctrl.PCMUX    = PCMUX_ADDER;
        ctrl.ADDR2MUX = ADDR2MUX_OFF9;
      end
      S12: begin
        ctrl.LD_PC    = 1'b1;
        ctrl.PCMUX    = PCMUX_ADDER;
        ctrl.ADDR1MUX = ADDR1MUX_SR1;
        ctrl.ADDR2MUX = ADDR2MUX_ZERO;
      end
      S04: begin
        ctrl.GatePC = 1'b1;
        ctrl.DRMUX  = DRMUX_R7;
        ctrl.LD_REG = 1'b1;
      end
      S21: begin
        ctrl.LD_PC = 1'b1;
        ctrl.PCMUX = PCMUX_ADDER;
        if (IR_11) begin
          ctrl.ADDR2MUX = ADDR2MUX_OFF11;
        end else begin
          ctrl.ADDR1MUX = ADDR1MUX_SR1;
          ctrl.ADDR2MUX = ADDR2MUX_ZERO;
        end
      end
      S06, S07: begin
        ctrl.GateMARMUX = 1'b1;
        ctrl.LD_MAR     = 1'b1;
        ctrl.ADDR1MUX   = ADDR1MUX_SR1;
        ctrl.ADDR2MUX   = ADDR2MUX_OFF6;
      end
      S27: begin
        ctrl.GateMDR = 1'b1;
        ctrl.LD_REG  = 1'b1;
        ctrl.LD_CC   = 1'b1;
      end
      S23: begin
        ctrl.GateALU = 1'b1;
        ctrl.LD_MDR  = 1'b1;
        ctrl.SR1MUX  = SR1MUX_IR11_9;
        ctrl.ALUK    = ALUK_PASSA;
      end
      S16_1, S16_2: Mem_WE = 1'b0;
      P1: ctrl.LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_isdu_ctrl.sv
// tb/tb_isdu_ctrl.sv - directed self-checking bench for isdu_ctrl
module tb_isdu_ctrl;
  import isdu_pkg::*;

  localparam logic [4:0] E_HALTED = 5'd0,  E_S18 = 5'd1,  E_S33_1 = 5'd2, E_S33_2 = 5'd3;
  localparam logic [4:0] E_S35 = 5'd4,  E_S32 = 5'd5,  E_S01 = 5'd6,  E_S00 = 5'd9;
  localparam logic [4:0] E_S22 = 5'd10, E_S04 = 5'd12, E_S21 = 5'd13, E_S07 = 5'd18;
  localparam logic [4:0] E_S23 = 5'd19, E_S16_1 = 5'd20, E_S16_2 = 5'd21, E_P1 = 5'd22;
  localparam logic [4:0] E_P2 = 5'd23;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  ctrl_t      ctrl;
  logic       Mem_OE, Mem_WE;
  logic [4:0] state_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cyc_s18;

  always #5 Clk = ~Clk;

  isdu_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .ctrl(ctrl), .Mem_OE(Mem_OE),
    .Mem_WE(Mem_WE), .state_o(state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    cyc++;
  endtask

  task automatic fetch();
    tick(); check("s33_1", state_o, E_S33_1); check("s33_1 oe", Mem_OE, 1'b0);
    check("s33_1 ld_pc", ctrl.LD_PC, 1'b0);
    tick(); check("s33_2", state_o, E_S33_2); check("s33_2 oe", Mem_OE, 1'b0);
    check("s33_2 ld_mdr", ctrl.LD_MDR, 1'b1);
    tick(); check("s35", state_o, E_S35); check("s35 ld_ir", ctrl.LD_IR, 1'b1);
    check("s35 gatemdr", ctrl.GateMDR, 1'b1); check("s35 oe", Mem_OE, 1'b1);
    tick(); check("s32", state_o, E_S32); check("s32 ld_ben", ctrl.LD_BEN, 1'b1);
  endtask

  task automatic at_s18(input string tag);
    check(tag, state_o, E_S18);
    check({tag, " ld_pc"}, ctrl.LD_PC, 1'b1);
    check({tag, " gatepc"}, ctrl.GatePC, 1'b1);
    check({tag, " ld_mar"}, ctrl.LD_MAR, 1'b1);
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0; Opcode = 4'b0000;
    IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
    repeat (2) tick();
    check("rst state", state_o, E_HALTED);
    check("rst ctrl", 32'(ctrl), 32'd0);
    check("rst oe", Mem_OE, 1'b1);
    check("rst we", Mem_WE, 1'b1);

    Reset = 1'b0;
    tick(); check("halted idle", state_o, E_HALTED);

    // ADD immediate, Run pulsed for one cycle
    Opcode = OP_ADD; IR_5 = 1'b1; Run = 1'b1;
    tick(); at_s18("add s18"); cyc_s18 = cyc;
    Run = 1'b0;
    fetch();
    tick(); check("s01", state_o, E_S01);
    check("s01 sr2mux", ctrl.SR2MUX, 1'b1); check("s01 ld_reg", ctrl.LD_REG, 1'b1);
    check("s01 ld_cc", ctrl.LD_CC, 1'b1); check("s01 gatealu", ctrl.GateALU, 1'b1);
    check("s01 aluk", ctrl.ALUK, 2'd0);
    tick(); at_s18("add next s18");
    check("add cycles", cyc - cyc_s18, 6);

    // BR not taken; Run held high to confirm it is ignored outside HALTED
    Opcode = OP_BR; BEN = 1'b0; Run = 1'b1;
    fetch();
    tick(); check("br s00", state_o, E_S00);
    tick(); check("br nt s18", state_o, E_S18);
    Run = 1'b0;

    BEN = 1'b1;
    fetch();
    tick(); check("br s00 t", state_o, E_S00);
    tick(); check("br s22", state_o, E_S22); check("s22 ld_pc", ctrl.LD_PC, 1'b1);
    check("s22 pcmux", ctrl.PCMUX, 2'd2); check("s22 addr2", ctrl.ADDR2MUX, 2'd2);
    tick(); check("br t s18", state_o, E_S18);

    // JSR PC-relative form
    Opcode = OP_JSR; IR_11 = 1'b1;
    fetch();
    tick(); check("s04", state_o, E_S04); check("s04 gatepc", ctrl.GatePC, 1'b1);
    check("s04 drmux", ctrl.DRMUX, 1'b1); check("s04 ld_reg", ctrl.LD_REG, 1'b1);
    tick(); check("s21", state_o, E_S21); check("s21 addr2", ctrl.ADDR2MUX, 2'd3);
    check("s21 addr1", ctrl.ADDR1MUX, 1'b0); check("s21 pcmux", ctrl.PCMUX, 2'd2);
    tick(); check("jsr s18", state_o, E_S18);

    // unassigned opcode falls straight back to fetch
    Opcode = 4'b1000;
    fetch();
    tick(); check("illegal s18", state_o, E_S18);

    // STR: write strobe only in the two wait states
    Opcode = OP_STR;
    fetch();
    tick(); check("s07", state_o, E_S07); check("s07 we", Mem_WE, 1'b1);
    check("s07 gatemarmux", ctrl.GateMARMUX, 1'b1); check("s07 addr2", ctrl.ADDR2MUX, 2'd1);
    tick(); check("s23", state_o, E_S23); check("s23 we", Mem_WE, 1'b1);
    check("s23 aluk", ctrl.ALUK, 2'd3); check("s23 sr1mux", ctrl.SR1MUX, 1'b1);
    tick(); check("s16_1", state_o, E_S16_1); check("s16_1 we", Mem_WE, 1'b0);
    tick(); check("s16_2", state_o, E_S16_2); check("s16_2 we", Mem_WE, 1'b0);
    tick(); check("str s18", state_o, E_S18); check("str s18 we", Mem_WE, 1'b1);

    // PAUSE holds until Continue rises then falls
    Opcode = OP_PSE;
    fetch();
    for (int i = 0; i < 10; i++) begin
      tick(); check("p1 hold", state_o, E_P1); check("p1 led", ctrl.LD_LED, 1'b1);
    end
    Continue = 1'b1;
    tick(); check("p2", state_o, E_P2); check("p2 led", ctrl.LD_LED, 1'b0);
    tick(); check("p2 hold", state_o, E_P2);
    Continue = 1'b0;
    tick(); check("pause s18", state_o, E_S18);

    // asynchronous reset in the middle of a memory write
    Opcode = OP_STR;
    fetch();
    tick(); tick(); tick(); check("pre-rst s16_1", state_o, E_S16_1);
    #2 Reset = 1'b1;
    #1 check("async we", Mem_WE, 1'b1); check("async state", state_o, E_HALTED);
    check("async ctrl", 32'(ctrl), 32'd0);
    tick(); Reset = 1'b0;
    tick(); check("post-rst halted", state_o, E_HALTED);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/isdu_ctrl.md
ISDU_CTRL -- requirements
Module: isdu_ctrl

Interface
REQ-001 Clk  input  1  rising-edge system clock.
REQ-002 Reset  input  1  reset, asynchronous, active-high.
REQ-003 Run  input  1  start request; level, synchronous to Clk.
REQ-004 Continue  input  1  resume request from pause; level, synchronous.
REQ-005 Opcode  input  4  IR[15:12] of current instruction.
REQ-006 IR_5  input  1  IR[5]; 1 = immediate operand for ADD/AND.
REQ-007 IR_11  input  1  IR[11]; JSR form select (1 = PC-relative).
REQ-008 BEN  input  1  registered branch-enable from the datapath.
REQ-009 ctrl  output  ctrl_t  packed datapath control word.
REQ-010 Mem_OE  output  1  memory output enable, active-low.
REQ-011 Mem_WE  output  1  memory write enable, active-low.
REQ-012 state_o  output  5  current state encoding, for debug display.

Function
REQ-013 The block SHALL be a single Moore FSM; ctrl, Mem_OE, Mem_WE SHALL be combinational from the state register only.
REQ-014 In every state, all ctrl fields not listed for that state SHALL be 0, and Mem_OE = Mem_WE = 1.
REQ-015 States and actions:
- HALTED: idle; -> S18 when Run = 1.
- S18: LD_MAR, GatePC, LD_PC, PCMUX = PC+1; -> S33_1.
- S33_1, S33_2: Mem_OE = 0; S33_2 adds LD_MDR; -> S35.
- S35: GateMDR, LD_IR; -> S32.
- S32: LD_BEN; dispatch on Opcode.
- ADD (0001) S01, AND (0101) S05: GateALU, LD_REG, LD_CC, SR2MUX = IR_5, ALUK = ADD or AND.
- NOT (1001) S09: GateALU, LD_REG, LD_CC, ALUK = NOT.
- BR (0000) S00: -> S22 if BEN else S18; S22: LD_PC, PCMUX = adder, ADDR2MUX = off9.
- JMP (1100) S12: LD_PC, PCMUX = adder, ADDR1MUX = SR1, ADDR2MUX = zero.
- JSR (0100) S04: GatePC, DRMUX = R7, LD_REG; -> S21; S21: LD_PC, PCMUX = adder, ADDR2MUX = off11 if IR_11, else ADDR1MUX = SR1 with ADDR2MUX = zero.
- LDR (0110) S06: GateMARMUX, LD_MAR, ADDR1MUX = SR1, ADDR2MUX = off6; -> S25_1, S25_2 (as S33_x); -> S27: GateMDR, LD_REG, LD_CC.
- STR (0111) S07: as S06; -> S23: GateALU, LD_MDR, SR1MUX = IR[11:9], ALUK = PASSA; -> S16_1, S16_2: Mem_WE = 0.
- PAUSE (1101) P1: LD_LED; -> P2 when Continue = 1; P2: -> S18 when Continue = 0.
- Any other opcode: -> S18.
REQ-016 All execute-terminal states (S01, S05, S09, S22, S12, S21, S27, S16_2) SHALL return to S18 on the next clock.
REQ-017 Memory accesses SHALL take exactly two wait states; a full ADD instruction SHALL take 6 cycles from S18 to the next S18.
REQ-018 Run SHALL be ignored outside HALTED; Continue SHALL be ignored outside P1/P2.
REQ-019 Exactly one Gate* bit SHALL be 1 in any state, or none.
REQ-020 state_o SHALL equal the encoding held in the package.

Reset
REQ-021 Reset = 1 SHALL force HALTED immediately, regardless of Clk, including mid-instruction and mid-memory-write (Mem_WE returns to 1 at once).
REQ-022 During and after reset, all ctrl fields SHALL be 0, Mem_OE = Mem_WE = 1, and state_o = 0.

Structure
REQ-023 Package isdu_pkg SHALL hold state_t (enum, HALTED = 0), ctrl_t (packed struct: LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED, GatePC, GateMDR, GateALU, GateMARMUX, PCMUX[1:0], DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX[1:0], ALUK[1:0]), and the opcode, ALUK and mux-code constants.
REQ-024 The block SHALL be a single module with no sub-modules; the next-state and output logic SHALL be separate combinational processes.

Verification
REQ-025 Reset, then Run = 1 for 1 cycle -> S18, S33_1, S33_2, S35, S32 in order; LD_PC = 1 only in S18.
REQ-026 Opcode = 0001, IR_5 = 1 -> S01 with SR2MUX = 1 and LD_REG = LD_CC = 1 for 1 cycle; S18 recurs 6 cycles after the prior S18.
REQ-027 Opcode = 0000: BEN = 0 -> S00 then S18; BEN = 1 -> S00, S22 (LD_PC = 1), S18.
REQ-028 Opcode = 0111 -> S07, S23, S16_1, S16_2 with Mem_WE = 0 in exactly those last 2 cycles.
REQ-029 Opcode = 1101, Continue held 0 for 10 cycles -> stays in P1 with LD_LED = 1; Continue 1 then 0 -> P2 then S18.
REQ-030 Reset asserted asynchronously while in S16_1 -> Mem_WE = 1 and state_o = 0 before the next Clk edge.
